mux_scan_sampler: RTL and testbench
===================================

Name: mux_scan_sampler

Overview:
- Sequential controller for the 4:1 mux stage. It drives the mux `sel` input through every channel in turn and samples the mux output `y` once per channel.
- It assembles the samples into a parallel snapshot of the mux inputs and hands that snapshot downstream on a valid/ready handshake.
- It is both the upstream driver of `sel` and the downstream consumer of `y`. A bench can check that `data` equals the mux `i` vector.

Parameters:
- N_CH, 4, number of mux channels (power of two, ≥2).
- SEL_W, 2, width of sel; must equal log2(N_CH).
- SETTLE, 1, extra cycles `sel` is held before sampling; allowed range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one full scan; honoured only in IDLE.
- y  input  1  mux output, sampled synchronously.
- sel  output  SEL_W  channel select driven to the mux.
- busy  output  1  high while a scan is in progress.
- data  output  N_CH  snapshot; bit k = y sampled while sel==k.
- valid  output  1  data is available.
- ready  input  1  downstream accepts data.

Behaviour:
- Reset (async, immediate): state=IDLE, sel=0, busy=0, valid=0, data=0, settle counter=0, shadow register=0.
- States: IDLE, HOLD, DONE.
- IDLE:
  - start=1 at an edge → HOLD; sel=0; counter=SETTLE; busy=1.
  - start=0 → stay in IDLE.
- HOLD, each edge:
  - counter≠0 → decrement; sel unchanged.
  - counter==0 → shadow[sel]=y.
  - If sel≠N_CH-1: sel=sel+1, counter=SETTLE, stay in HOLD.
  - Else: data = shadow with bit N_CH-1 replaced by the current y (same edge); sel=0; busy=0; valid=1; → DONE.
- Channel timing: each channel is driven for exactly SETTLE+1 cycles.
- Latency: valid rises N_CH*(SETTLE+1) edges after the edge that accepts start. Defaults: 8 edges.
- DONE:
  - valid held high; data held stable.
  - ready=1 at an edge → valid=0, → IDLE.
  - If start=1 on that same edge, the new scan is accepted directly: → HOLD, sel=0, busy=1, valid=0.
- Handshake rules:
  - ready while valid=0 has no effect.
  - data changes only at scan completion, never mid-scan.
  - The previous data is retained after the handshake, until the next completion.
- start while HOLD, or while DONE without ready: ignored, not queued.
- Reset mid-scan: partial samples are discarded. After release the block waits in IDLE for a fresh start.
- sel is a registered output, glitch-free. It changes only on clock edges.
- The counter width is 4 bits. SETTLE=0 means sel advances every cycle.

Decomposition:
- Shared package/header `mux_scan_defs`:
  - state encodings S_IDLE=2'd0, S_HOLD=2'd1, S_DONE=2'd2 (2'd3 unreachable; decode to IDLE).
  - default N_CH/SEL_W constants.
- One natural sub-module: `settle_counter`.
  - Loadable down-counter with load, value and zero-flag.
  - Instantiated once.
- Everything else (FSM, sel register, shadow and data registers) stays in the top module.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge → sel=0, busy=0, valid=0, data=4'b0000 immediately.
- Basic scan: SETTLE=1, mux real with i=4'b1010, pulse start → valid rises exactly 8 edges later; data=4'b1010; sel sequence 0,0,1,1,2,2,3,3 then back to 0.
- Walking one:
  - Scan four times with i=0001, 0010, 0100, 1000.
  - Complete each handshake with ready=1 for one cycle.
  - Each data equals i; valid drops the edge after ready.
- Back-pressure:
  - Hold ready=0 for 20 cycles after valid while toggling start and changing i → data and valid stay unchanged; no new scan starts.
  - Then ready=1 together with start=1 → next scan begins that edge, busy=1.
- Mid-scan reset: start a scan, assert rst when sel=2, release → IDLE, valid=0, data=0; a fresh scan with i=4'b0110 returns 4'b0110.
- SETTLE=0 instance with i=4'b1100 → valid 4 edges after start; data=4'b1100; sel advances every cycle.

Source files
------------

// File: rtl/mux_scan_sampler_pkg.sv
// rtl/mux_scan_sampler_pkg.sv - shared state encodings and default sizes for the mux scan sampler
package mux_scan_defs;

  localparam int N_CH_DEF  = 4;
  localparam int SEL_W_DEF = 2;
  localparam int CNT_W     = 4;

  // 2'd3 is never entered; the FSM decodes it back to IDLE
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_sampler_if.sv
// rtl/mux_scan_sampler_if.sv - mux-side and downstream handshake bundle for the scan sampler
interface mux_scan_if #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
);
  logic             start;
  logic             y;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic [N_CH-1:0]  data;
  logic             valid;
  logic             ready;

  modport master (
    input  start, y, ready,
    output sel, busy, data, valid
  );

  modport slave (
    output start, y, ready,
    input  sel, busy, data, valid
  );
endinterface

// File: rtl/mux_scan_sampler_settle_counter.sv
// rtl/mux_scan_sampler_settle_counter.sv - loadable down-counter timing how long each channel is held
module settle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);
endmodule

// File: rtl/mux_scan_sampler.sv
// rtl/mux_scan_sampler.sv - steps mux sel through every channel, samples y, hands snapshot downstream
import mux_scan_defs::*;

module mux_scan_sampler #(
  parameter int N_CH   = N_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = 1
) (
  input  logic      clk,
  input  logic      rst,
  mux_scan_if.master bus
);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic             busy_q;
  logic             valid_q;
  logic [N_CH-1:0]  data_q;
  logic [N_CH-1:0]  shadow_q;
  logic [N_CH-1:0]  snap_d;

  logic             start_acc;
  logic             sample;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  always_comb begin
    start_acc = bus.start && (state_q == S_IDLE || (state_q == S_DONE && bus.ready));
    sample    = (state_q == S_HOLD) && cnt_zero;
    cnt_load  = start_acc || (sample && sel_q != LAST_SEL);
    cnt_dec   = (state_q == S_HOLD) && (cnt_val != '0);
    // last channel goes straight into data on the completing edge
    snap_d           = shadow_q;
    snap_d[N_CH-1]   = bus.y;
  end

  settle_counter #(.W(CNT_W)) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (SETTLE_LD),
    .dec_i      (cnt_dec),
    .value_o    (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      shadow_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_HOLD;
            sel_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            shadow_q[sel_q] <= bus.y;
            if (sel_q != LAST_SEL) begin
              sel_q <= sel_q + SEL_W'(1);
            end else begin
              data_q  <= snap_d;
              sel_q   <= '0;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.ready) begin
            valid_q <= 1'b0;
            if (bus.start) begin
              state_q <= S_HOLD;
              sel_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.data  = data_q;
endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb/tb_mux_scan_sampler.sv - directed bench for the mux scan sampler (SETTLE=1 and SETTLE=0 instances)
module tb_mux_scan_sampler;
  logic       clk;
  logic       rst;
  logic [3:0] i1;
  logic [3:0] i0;
  int         vec;
  int         err;

  mux_scan_if #(.N_CH(4), .SEL_W(2)) b1 ();
  mux_scan_if #(.N_CH(4), .SEL_W(2)) b0 ();

  assign b1.y = i1[b1.sel];
  assign b0.y = i0[b0.sel];

  mux_scan_sampler #(.N_CH(4), .SEL_W(2), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mux_scan_sampler #(.N_CH(4), .SEL_W(2), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vec++; if (b1.sel !== 2'd0) begin err++; $display("FAIL reset_sel: got %0d expected 0", b1.sel); end
    vec++; if (b1.busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b expected 0", b1.busy); end
    vec++; if (b1.valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b expected 0", b1.valid); end
    vec++; if (b1.data !== 4'b0000) begin err++; $display("FAIL reset_data: got %b expected 0000", b1.data); end
    vec++; if (b0.valid !== 1'b0) begin err++; $display("FAIL reset_valid0: got %b expected 0", b0.valid); end
    tick();
    tick();
    rst = 1'b0;
    b1.ready = 1'b1;
    tick();
    tick();
    vec++; if (b1.valid !== 1'b0 || b1.busy !== 1'b0) begin err++; $display("FAIL idle_ready_noeffect: got valid=%b busy=%b expected 0 0", b1.valid, b1.busy); end
    b1.ready = 1'b0;
  endtask

  task automatic test_basic();
    i1 = 4'b1010;
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    vec++; if (b1.sel !== 2'd0 || b1.busy !== 1'b1) begin err++; $display("FAIL basic_accept: got sel=%0d busy=%b expected 0 1", b1.sel, b1.busy); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      vec++; if (b1.sel !== ((k < 8) ? 2'(k / 2) : 2'd0)) begin err++; $display("FAIL basic_sel[%0d]: got %0d expected %0d", k, b1.sel, (k < 8) ? k / 2 : 0); end
      vec++; if (b1.valid !== (k == 8)) begin err++; $display("FAIL basic_valid[%0d]: got %b expected %b", k, b1.valid, k == 8); end
    end
    vec++; if (b1.data !== 4'b1010) begin err++; $display("FAIL basic_data: got %b expected 1010", b1.data); end
    vec++; if (b1.busy !== 1'b0) begin err++; $display("FAIL basic_busy_done: got %b expected 0", b1.busy); end
    b1.ready = 1'b1;
    tick();
    b1.ready = 1'b0;
    vec++; if (b1.valid !== 1'b0 || b1.data !== 4'b1010) begin err++; $display("FAIL basic_handshake: got valid=%b data=%b expected 0 1010", b1.valid, b1.data); end
  endtask

  task automatic test_walking();
    logic [3:0] pat;
    int n;
    for (int w = 0; w < 4; w++) begin
      pat = 4'b0001 << w;
      i1 = pat;
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      n = 0;
      while (b1.valid !== 1'b1 && n < 20) begin tick(); n++; end
      vec++; if (n != 8) begin err++; $display("FAIL walk_latency[%0d]: got %0d expected 8", w, n); end
      vec++; if (b1.data !== pat) begin err++; $display("FAIL walk_data[%0d]: got %b expected %b", w, b1.data, pat); end
      b1.ready = 1'b1;
      tick();
      b1.ready = 1'b0;
      vec++; if (b1.valid !== 1'b0) begin err++; $display("FAIL walk_valid_drop[%0d]: got %b expected 0", w, b1.valid); end
    end
  endtask

  task automatic test_back_pressure();
    int n;
    i1 = 4'b0101;
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    n = 0;
    while (b1.valid !== 1'b1 && n < 20) begin tick(); n++; end
    vec++; if (b1.data !== 4'b0101 || n != 8) begin err++; $display("FAIL bp_first: got data=%b lat=%0d expected 0101 8", b1.data, n); end
    for (int k = 0; k < 20; k++) begin
      b1.start = k[0];
      i1 = 4'(k * 3);
      tick();
      vec++; if (b1.valid !== 1'b1 || b1.data !== 4'b0101 || b1.busy !== 1'b0) begin
        err++; $display("FAIL bp_hold[%0d]: got valid=%b data=%b busy=%b expected 1 0101 0", k, b1.valid, b1.data, b1.busy);
      end
    end
    i1 = 4'b0011;
    b1.start = 1'b1;
    b1.ready = 1'b1;
    tick();
    b1.start = 1'b0;
    b1.ready = 1'b0;
    vec++; if (b1.busy !== 1'b1 || b1.valid !== 1'b0 || b1.sel !== 2'd0) begin err++; $display("FAIL bp_restart: got busy=%b valid=%b sel=%0d expected 1 0 0", b1.busy, b1.valid, b1.sel); end
    vec++; if (b1.data !== 4'b0101) begin err++; $display("FAIL bp_retain: got %b expected 0101", b1.data); end
    n = 0;
    while (b1.valid !== 1'b1 && n < 20) begin tick(); n++; end
    vec++; if (b1.data !== 4'b0011 || n != 8) begin err++; $display("FAIL bp_second: got data=%b lat=%0d expected 0011 8", b1.data, n); end
    b1.ready = 1'b1;
    tick();
    b1.ready = 1'b0;
  endtask

  task automatic test_mid_scan_reset();
    int n;
    i1 = 4'b1111;
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    n = 0;
    while (b1.sel !== 2'd2 && n < 20) begin tick(); n++; end
    vec++; if (b1.sel !== 2'd2) begin err++; $display("FAIL mid_reach_sel2: got %0d expected 2", b1.sel); end
    #2;
    rst = 1'b1;
    #1;
    vec++; if (b1.sel !== 2'd0 || b1.busy !== 1'b0 || b1.valid !== 1'b0 || b1.data !== 4'b0000) begin
      err++; $display("FAIL mid_reset_async: got sel=%0d busy=%b valid=%b data=%b expected 0 0 0 0000", b1.sel, b1.busy, b1.valid, b1.data);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    vec++; if (b1.busy !== 1'b0 || b1.valid !== 1'b0) begin err++; $display("FAIL mid_stay_idle: got busy=%b valid=%b expected 0 0", b1.busy, b1.valid); end
    i1 = 4'b0110;
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    n = 0;
    while (b1.valid !== 1'b1 && n < 20) begin tick(); n++; end
    vec++; if (b1.data !== 4'b0110 || n != 8) begin err++; $display("FAIL mid_fresh_scan: got data=%b lat=%0d expected 0110 8", b1.data, n); end
    b1.ready = 1'b1;
    tick();
    b1.ready = 1'b0;
  endtask

  task automatic test_settle0();
    i0 = 4'b1100;
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    vec++; if (b0.sel !== 2'd0 || b0.busy !== 1'b1) begin err++; $display("FAIL s0_accept: got sel=%0d busy=%b expected 0 1", b0.sel, b0.busy); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      vec++; if (b0.sel !== ((k < 4) ? 2'(k) : 2'd0)) begin err++; $display("FAIL s0_sel[%0d]: got %0d expected %0d", k, b0.sel, (k < 4) ? k : 0); end
      vec++; if (b0.valid !== (k == 4)) begin err++; $display("FAIL s0_valid[%0d]: got %b expected %b", k, b0.valid, k == 4); end
    end
    vec++; if (b0.data !== 4'b1100) begin err++; $display("FAIL s0_data: got %b expected 1100", b0.data); end
    b0.ready = 1'b1;
    tick();
    b0.ready = 1'b0;
    vec++; if (b0.valid !== 1'b0) begin err++; $display("FAIL s0_handshake: got %b expected 0", b0.valid); end
  endtask

  initial begin
    vec = 0;
    err = 0;
    i1 = 4'b0000;
    i0 = 4'b0000;
    b1.start = 1'b0;
    b1.ready = 1'b0;
    b0.start = 1'b0;
    b0.ready = 1'b0;
    test_reset();
    test_basic();
    test_walking();
    test_back_pressure();
    test_mid_scan_reset();
    test_settle0();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
